minmax_stream: RTL and testbench

MINMAX_STREAM -- requirements
Module: minmax_stream

---
 rtl/minmax_pkg.sv | 6 +
 rtl/minmax_cmp.sv | 20 ++
 rtl/minmax_stream.sv | 90 +++++++++
 tb/tb_minmax_stream.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// minmax_pkg: shared configuration and state enums for the min/max stream block
package minmax_pkg;
    typedef enum logic [1:0] {MM_BOTH, MIN_ONLY, MAX_ONLY} mm_cfg_e;
    typedef enum logic [1:0] {US_BOTH, UNSIGNED_ONLY, SIGNED_ONLY} us_cfg_e;
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;
endpackage

// File: rtl/minmax_cmp.sv
// minmax_cmp: strict "candidate beats best" compare, signed or unsigned, min or max
module minmax_cmp
    import minmax_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] cand,
    input  logic [W-1:0] best,
    input  logic         sgn,
    input  logic         max,
    output logic         beats
);
    logic lt, gt;
    // strict compare only, so ties never replace the earlier sample
    always_comb begin
        lt    = sgn ? ($signed(cand) < $signed(best)) : (cand < best);
        gt    = sgn ? ($signed(cand) > $signed(best)) : (cand > best);
        beats = max ? gt : lt;
    end
endmodule

// File: rtl/minmax_stream.sv
// minmax_stream: per-frame min/max finder; MINMAX_STREAM_INDEX_EN adds out_index
module minmax_stream
    import minmax_pkg::*;
#(
    parameter int W      = 5,
    parameter int NI     = 64,
    parameter int IDXW   = $clog2(NI),
    parameter int MM_CFG = 1,
    parameter int US_CFG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    input  logic         us_sel,
    input  logic         min_max_sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
`ifdef MINMAX_STREAM_INDEX_EN
    output logic [IDXW-1:0] out_index,
`endif
    output logic         out_trunc
);
    localparam int CW = $clog2(NI + 1);

    state_e        state;
    logic          alive, us_q, mm_q, trunc, beats, acc, done, us_eff, mm_eff;
    logic [W-1:0]  best;
    logic [CW-1:0] cnt, cnt_nxt;
`ifdef MINMAX_STREAM_INDEX_EN
    logic [IDXW-1:0] best_idx;
    assign out_index = best_idx;
`endif

    assign us_eff     = (US_CFG == int'(UNSIGNED_ONLY)) ? 1'b0 : (US_CFG == int'(SIGNED_ONLY)) ? 1'b1 : us_sel;
    assign mm_eff     = (MM_CFG == int'(MIN_ONLY)) ? 1'b0 : (MM_CFG == int'(MAX_ONLY)) ? 1'b1 : min_max_sel;
    assign in_ready   = alive && state != HOLD;
    assign out_valid  = state == HOLD;
    assign out_result = best;
    assign out_trunc  = trunc;
    assign acc        = in_valid && in_ready;
    assign cnt_nxt    = (state == IDLE ? '0 : cnt) + CW'(1);
    assign done       = in_last || cnt_nxt == CW'(NI);

    minmax_cmp #(.W(W)) u_cmp (
        .cand  (in_data),
        .best  (best),
        .sgn   (us_q),
        .max   (mm_q),
        .beats (beats)
    );

    // frame FSM: first beat loads, later beats replace on a strict win, last or NI-th beat closes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            alive <= 1'b0;
            best  <= '0;
            cnt   <= '0;
            trunc <= 1'b0;
            us_q  <= 1'b0;
            mm_q  <= 1'b0;
`ifdef MINMAX_STREAM_INDEX_EN
            best_idx <= '0;
`endif
        end else begin
            alive <= 1'b1;
            if (acc) begin
                if (state == IDLE || beats) begin
                    best <= in_data;
`ifdef MINMAX_STREAM_INDEX_EN
                    best_idx <= (state == IDLE) ? '0 : cnt[IDXW-1:0];
`endif
                end
                if (state == IDLE) begin
                    us_q <= us_eff;
                    mm_q <= mm_eff;
                end
                cnt   <= cnt_nxt;
                state <= done ? HOLD : ACC;
                if (done) trunc <= !in_last;
            end else if (state == HOLD && out_ready) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_minmax_stream.sv
// tb_minmax_stream: directed and random frames against a queue-based min/max model
module tb_minmax_stream;
    localparam int W = 5, NI = 4, IDXW = $clog2(NI);

    logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, us_sel = 0, min_max_sel = 0, out_ready = 1;
    logic [W-1:0] in_data = '0;
    logic in_ready, out_valid, out_trunc;
    logic [W-1:0] out_result;
`ifdef MINMAX_STREAM_INDEX_EN
    logic [IDXW-1:0] out_index;
`endif

    typedef struct {int res; int idx; int trunc;} exp_t;
    exp_t exp_q[$];
    int   samp[$];
    int   n_chk = 0, n_fail = 0;
    bit   open = 0, fus = 0, fmm = 0, pend_lat = 0, prev_hs = 0, ready_rand = 0;

    always #5 clk = ~clk;

    minmax_stream #(.W(W), .NI(NI), .MM_CFG(0), .US_CFG(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .us_sel      (us_sel),
        .min_max_sel (min_max_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
`ifdef MINMAX_STREAM_INDEX_EN
        .out_index   (out_index),
`endif
        .out_trunc   (out_trunc)
    );

    task automatic check(string tag, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int sval(int x, bit sgn);
        return (sgn && x >= (1 << (W - 1))) ? x - (1 << W) : x;
    endfunction

    function automatic exp_t winner(bit trunc);
        exp_t e;
        e.res = samp[0]; e.idx = 0; e.trunc = int'(trunc);
        for (int i = 1; i < samp.size(); i++)
            if (fmm ? sval(samp[i], fus) > sval(e.res, fus) : sval(samp[i], fus) < sval(e.res, fus)) begin
                e.res = samp[i]; e.idx = i;
            end
        return e;
    endfunction

    // monitor: sample at negedge, far from the active edge
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_in_ready", int'(in_ready), 0);
            check("rst_result", int'(out_result), 0);
            check("rst_trunc", int'(out_trunc), 0);
            exp_q.delete(); samp.delete();
            open = 0; pend_lat = 0; prev_hs = 0;
        end else begin
            if (pend_lat) check("latency", int'(out_valid), 1);
            pend_lat = 0;
            if (prev_hs) check("ready_after_hs", int'(in_ready), 1);
            prev_hs = 0;
            if (out_valid) begin
                check("hold_in_ready", int'(in_ready), 0);
                check("valid_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    check("result", int'(out_result), exp_q[0].res);
                    check("trunc", int'(out_trunc), exp_q[0].trunc);
`ifdef MINMAX_STREAM_INDEX_EN
                    check("index", int'(out_index), exp_q[0].idx);
`endif
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        prev_hs = 1;
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (!open) begin
                    open = 1; fus = us_sel; fmm = min_max_sel;
                end
                samp.push_back(int'(in_data));
                if (in_last || samp.size() == NI) begin
                    exp_q.push_back(winner(!in_last));
                    samp.delete();
                    open = 0; pend_lat = 1;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (ready_rand) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(int d, bit l, bit u = 0, bit m = 0);
        in_valid = 1; in_data = W'(d); in_last = l; us_sel = u; min_max_sel = m;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("send_accept", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 0; in_last = 0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && exp_q.size() > 0; n++) @(posedge clk);
        check("drain", exp_q.size(), 0);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3 rst_n = 1;
        check("ready_before_edge", int'(in_ready), 0);
        @(posedge clk);
        #1 check("ready_after_release", int'(in_ready), 1);
        // min unsigned: 3 at index 1
        send(7, 0); send(3, 0); send(9, 0); send(3, 1);
        idle(2);
        // max signed: 2 at index 1; max unsigned: 31 at index 0
        send('h1F, 0, 1, 1); send('h02, 0, 1, 1); send('h10, 1, 1, 1);
        send('h1F, 0, 0, 1); send('h02, 0, 0, 1); send('h10, 1, 0, 1);
        // cut at NI=4: 1 truncated, then 2 from the remaining two beats
        send(4, 0); send(1, 0); send(6, 0); send(2, 0); send(2, 0); send(5, 1);
        drain();
        // result held with out_ready low for 5 cycles
        out_ready = 0;
        send(8, 0); send(6, 1);
        idle(5);
        out_ready = 1;
        send(11, 1);
        // selects changed mid-frame have no effect: min unsigned gives 1
        send(3, 0, 0, 0); send(9, 0, 1, 1); send(1, 0, 1, 1); send(5, 1, 1, 1);
        drain();
        // reset after two beats discards the partial frame
        send(10, 0); send(12, 0);
        rst_n = 0;
        @(posedge clk);
        #3 rst_n = 1;
        check("ready_before_edge2", int'(in_ready), 0);
        @(posedge clk);
        #1 check("ready_after_release2", int'(in_ready), 1);
        send(4, 1);
        drain();
        // random frames, some longer than NI, random selects per beat and random backpressure
        ready_rand = 1;
        for (int f = 0; f < 60; f++) begin
            int len;
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) begin
                send(int'($urandom_range(0, 31)), i == len - 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        ready_rand = 0;
        out_ready = 1;
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
